// File: rtl/corejtagdebug_tgt_tap_responder.sv
// corejtagdebug_tgt_tap_responder
// IEEE 1149.1 target TAP responder: TAP controller, instruction register,
// IDCODE / BYPASS / 32-bit USER data registers. The USER register hands
// captured and updated values to on-chip debug logic.
module corejtagdebug_tgt_tap_responder #(
    parameter int unsigned                IR_REG_WIDTH = 5,
    parameter int unsigned                DR_REG_WIDTH = 32,
    parameter logic [31:0]                IDCODE_VAL   = 32'h1000_05CF,
    parameter logic [IR_REG_WIDTH-1:0]    IR_IDCODE    = 5'h01,
    parameter logic [IR_REG_WIDTH-1:0]    IR_USER      = 5'h15
) (
    input  logic                    TCK,
    input  logic                    TRST,
    input  logic                    TMS,
    input  logic                    TDI,
    output logic                    TDO,
    output logic                    TDO_OE,
    input  logic [DR_REG_WIDTH-1:0] USER_CAPTURE_DATA,
    output logic [DR_REG_WIDTH-1:0] USER_UPDATE_DATA,
    output logic                    USER_UPDATE_STB,
    output logic [3:0]              TAP_STATE,
    output logic [IR_REG_WIDTH-1:0] IR_OUT
);

    // Shift register is wide enough for both the IDCODE and the USER register.
    localparam int unsigned SR_W = (DR_REG_WIDTH > 32) ? DR_REG_WIDTH : 32;

    // Value loaded into the IR shift register in Capture-IR.
    localparam logic [IR_REG_WIDTH-1:0] IR_CAPTURE = {{(IR_REG_WIDTH-2){1'b0}}, 2'b01};

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    tap_state_t                state;
    tap_state_t                next_state;
    logic [IR_REG_WIDTH-1:0]   ir;
    logic [IR_REG_WIDTH-1:0]   ir_sr;
    logic [SR_W-1:0]           dr_sr;
    logic [SR_W-1:0]           dr_capture;
    logic [SR_W-1:0]           dr_shifted;
    int unsigned               dr_len;
    logic                      in_shift;
    logic                      tdo_next;

    // TAP controller state register.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // TAP next-state decode and shift-phase outputs feeding the falling-edge TDO stage.
    always_comb begin
        next_state = state;
        in_shift   = 1'b0;
        tdo_next   = 1'b0;
        case (state)
            TLR:    next_state = TMS ? TLR    : RTI;
            RTI:    next_state = TMS ? SEL_DR : RTI;
            SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
            CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
            SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
            EX1_DR: next_state = TMS ? UPD_DR : PAU_DR;
            PAU_DR: next_state = TMS ? EX2_DR : PAU_DR;
            EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
            UPD_DR: next_state = TMS ? SEL_DR : RTI;
            SEL_IR: next_state = TMS ? TLR    : CAP_IR;
            CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
            SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
            EX1_IR: next_state = TMS ? UPD_IR : PAU_IR;
            PAU_IR: next_state = TMS ? EX2_IR : PAU_IR;
            EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
            UPD_IR: next_state = TMS ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
        if (state == SH_IR) begin
            in_shift = 1'b1;
            tdo_next = ir_sr[0];
        end else if (state == SH_DR) begin
            in_shift = 1'b1;
            tdo_next = dr_sr[0];
        end
    end

    // Selected data register: length and capture value follow the active instruction.
    always_comb begin
        dr_capture = '0;
        if (ir == IR_IDCODE) begin
            dr_len           = 32;
            dr_capture[31:0] = IDCODE_VAL;
        end else if (ir == IR_USER) begin
            dr_len                       = DR_REG_WIDTH;
            dr_capture[DR_REG_WIDTH-1:0] = USER_CAPTURE_DATA;
        end else begin
            dr_len = 1;
        end
    end

    // One LSB-first shift step: TDI enters at bit dr_len-1, bits above it are unused.
    always_comb begin
        dr_shifted = '0;
        for (int unsigned i = 0; i < SR_W - 1; i++) begin
            if (i + 1 == dr_len) begin
                dr_shifted[i] = TDI;
            end else if (i + 1 < dr_len) begin
                dr_shifted[i] = dr_sr[i+1];
            end
        end
        if (dr_len == SR_W) begin
            dr_shifted[SR_W-1] = TDI;
        end
    end

    // Capture / shift / update actions on the rising edge that leaves each state.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir               <= IR_IDCODE;
            ir_sr            <= '0;
            dr_sr            <= '0;
            USER_UPDATE_DATA <= '0;
            USER_UPDATE_STB  <= 1'b0;
        end else begin
            USER_UPDATE_STB <= 1'b0;
            case (state)
                CAP_IR: ir_sr <= IR_CAPTURE;
                SH_IR:  ir_sr <= {TDI, ir_sr[IR_REG_WIDTH-1:1]};
                CAP_DR: dr_sr <= dr_capture;
                SH_DR:  dr_sr <= dr_shifted;
                UPD_DR: begin
                    if (ir == IR_USER) begin
                        USER_UPDATE_DATA <= dr_sr[DR_REG_WIDTH-1:0];
                        USER_UPDATE_STB  <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Entering Test-Logic-Reset must take effect on the same edge,
            // so it is keyed on next_state rather than on state == TLR.
            if (next_state == TLR) begin
                ir <= IR_IDCODE;
            end else if (state == UPD_IR) begin
                ir <= ir_sr;
            end
        end
    end

    // TDO and its enable change only on falling edges so the host samples on the rise.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_OE <= 1'b0;
        end else begin
            TDO    <= tdo_next;
            TDO_OE <= in_shift;
        end
    end

    assign TAP_STATE = state;
    assign IR_OUT    = ir;

endmodule
